// File: rtl/pc_pkg.sv
// Shared types and default vectors for the program-counter generator.
// Optional feature macro: PC_GEN_COMPRESSED_EN (see pc_next_mux / pc_gen).
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    typedef enum logic [1:0] {
        SEL_HOLD     = 2'd0,
        SEL_INC      = 2'd1,
        SEL_REDIRECT = 2'd2,
        SEL_TRAP     = 2'd3
    } next_sel_t;

    localparam logic [31:0] PC_RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VECTOR_DEF  = 32'h0000_0100;
    localparam int          PC_INC_DEF          = 4;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: trap > redirect > hold > increment.
// With PC_GEN_COMPRESSED_EN defined, is_compressed selects a 2-byte step and
// only bit 0 of a redirect target is checked for alignment.
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(PC_TRAP_VECTOR_DEF),
    parameter int              INC         = PC_INC_DEF
) (
    input  pc_state_t         state,
    input  logic [XLEN-1:0]   pc,
    input  logic              stall,
    input  logic              fetch_ready,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_target,
    input  logic              redirect_is_jalr,
    input  logic              trap_valid,
`ifdef PC_GEN_COMPRESSED_EN
    input  logic              is_compressed,
`endif
    output next_sel_t         next_sel,
    output logic [XLEN-1:0]   next_pc,
    output logic [XLEN-1:0]   redirect_eff,
    output logic              misalign_hit
);

    // JALR targets have bit 0 cleared before any other use.
    function automatic logic [XLEN-1:0] eff_target(input logic [XLEN-1:0] t,
                                                   input logic jalr);
        logic [XLEN-1:0] r;
        r = t;
        if (jalr) r[0] = 1'b0;
        return r;
    endfunction

    function automatic logic is_misaligned(input logic [XLEN-1:0] t);
`ifdef PC_GEN_COMPRESSED_EN
        return t[0];
`else
        return |t[1:0];
`endif
    endfunction

    logic [XLEN-1:0] inc_amt;

`ifdef PC_GEN_COMPRESSED_EN
    assign inc_amt = is_compressed ? XLEN'(2) : XLEN'(INC);
`else
    assign inc_amt = XLEN'(INC);
`endif

    assign redirect_eff = eff_target(redirect_target, redirect_is_jalr);

    // Priority decode of the PC source; BOOT always holds, HALT only reacts to traps.
    always_comb begin
        next_sel     = SEL_HOLD;
        misalign_hit = 1'b0;
        unique case (state)
            RUN: begin
                if (trap_valid) begin
                    next_sel = SEL_TRAP;
                end else if (redirect_valid) begin
                    if (is_misaligned(redirect_eff)) begin
                        next_sel     = SEL_TRAP;
                        misalign_hit = 1'b1;
                    end else begin
                        next_sel = SEL_REDIRECT;
                    end
                end else if (stall || !fetch_ready) begin
                    next_sel = SEL_HOLD;
                end else begin
                    next_sel = SEL_INC;
                end
            end
            HALT: begin
                if (trap_valid) next_sel = SEL_TRAP;
            end
            default: next_sel = SEL_HOLD;
        endcase
    end

    // Address selected by the decode above; the increment wraps modulo 2^XLEN.
    always_comb begin
        next_pc = pc;
        unique case (next_sel)
            SEL_TRAP:     next_pc = TRAP_VECTOR;
            SEL_REDIRECT: next_pc = redirect_eff;
            SEL_INC:      next_pc = pc + inc_amt;
            default:      next_pc = pc;
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: holds the fetch PC, the BOOT/RUN/HALT FSM,
// the exception PC and the misalignment pulse. Next-PC logic lives in
// pc_next_mux. Optional feature macro: PC_GEN_COMPRESSED_EN adds the
// is_compressed input (2-byte sequential step, 2-byte-aligned redirects).
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR_DEF),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(PC_TRAP_VECTOR_DEF),
    parameter int              INC          = PC_INC_DEF
) (
    input  logic              clk,
    input  logic              a_reset_n,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_target,
    input  logic              redirect_is_jalr,
    input  logic              trap_valid,
    input  logic              halt_req,
    input  logic              resume,
    input  logic              fetch_ready,
`ifdef PC_GEN_COMPRESSED_EN
    input  logic              is_compressed,
`endif
    output logic              fetch_valid,
    output logic [XLEN-1:0]   cmd_address_current,
    output logic [XLEN-1:0]   cmd_address_next,
    output logic [XLEN-1:0]   epc,
    output logic              misaligned
);

    pc_state_t       state;
    pc_state_t       state_next;
    next_sel_t       next_sel;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] redirect_eff;
    logic            misalign_hit;

    pc_next_mux #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR),
        .INC         (INC)
    ) u_next_mux (
        .state            (state),
        .pc               (pc),
        .stall            (stall),
        .fetch_ready      (fetch_ready),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .redirect_is_jalr (redirect_is_jalr),
        .trap_valid       (trap_valid),
`ifdef PC_GEN_COMPRESSED_EN
        .is_compressed    (is_compressed),
`endif
        .next_sel         (next_sel),
        .next_pc          (next_pc),
        .redirect_eff     (redirect_eff),
        .misalign_hit     (misalign_hit)
    );

    assign cmd_address_current = pc;
    assign cmd_address_next    = next_pc;

    // PC, exception PC and one-cycle misalignment pulse.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            pc         <= RESET_VECTOR;
            epc        <= '0;
            misaligned <= 1'b0;
        end else begin
            pc         <= next_pc;
            misaligned <= misalign_hit;
            if (next_sel == SEL_TRAP) begin
                // A misaligned redirect records the offending target, a real trap the current PC.
                epc <= misalign_hit ? redirect_eff : pc;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and fetch request; a trap beats halt_req, halt_req beats resume.
    always_comb begin
        state_next  = state;
        fetch_valid = 1'b0;
        unique case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                fetch_valid = 1'b1;
                if (trap_valid)    state_next = RUN;
                else if (halt_req) state_next = HALT;
            end
            HALT: begin
                if (trap_valid)    state_next = RUN;
                else if (halt_req) state_next = HALT;
                else if (resume)   state_next = RUN;
            end
            default: state_next = BOOT;
        endcase
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen; expectations follow whether
// PC_GEN_COMPRESSED_EN is defined for the build.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        a_reset_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        redirect_is_jalr;
    logic        trap_valid;
    logic        halt_req;
    logic        resume;
    logic        fetch_ready;
    logic        is_compressed;
    logic        fetch_valid;
    logic [31:0] cmd_address_current;
    logic [31:0] cmd_address_next;
    logic [31:0] epc;
    logic        misaligned;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk                 (clk),
        .a_reset_n           (a_reset_n),
        .stall               (stall),
        .redirect_valid      (redirect_valid),
        .redirect_target     (redirect_target),
        .redirect_is_jalr    (redirect_is_jalr),
        .trap_valid          (trap_valid),
        .halt_req            (halt_req),
        .resume              (resume),
        .fetch_ready         (fetch_ready),
`ifdef PC_GEN_COMPRESSED_EN
        .is_compressed       (is_compressed),
`endif
        .fetch_valid         (fetch_valid),
        .cmd_address_current (cmd_address_current),
        .cmd_address_next    (cmd_address_next),
        .epc                 (epc),
        .misaligned          (misaligned)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redirect_valid = 1'b1; redirect_target = t;
        tick();
        redirect_valid = 1'b0; redirect_target = '0;
    endtask

    task automatic test_reset();
        a_reset_n = 1'b0; stall = 0; redirect_valid = 0; redirect_target = '0;
        redirect_is_jalr = 0; trap_valid = 0; halt_req = 0; resume = 0;
        fetch_ready = 1; is_compressed = 0;
        #23;
        total++; if (cmd_address_current !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=%h", cmd_address_current, 32'h0); end
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL rst_fv got=%b exp=0", fetch_valid); end
        total++; if (epc !== 32'h0 || misaligned !== 1'b0) begin bad++; $display("FAIL rst_epc_mis got=%h/%b exp=0/0", epc, misaligned); end
        @(negedge clk);
        a_reset_n = 1'b1;
        #1;
        total++; if (fetch_valid !== 1'b0 || cmd_address_next !== 32'h0) begin bad++; $display("FAIL boot got fv=%b next=%h exp fv=0 next=0", fetch_valid, cmd_address_next); end
        tick();
        total++; if (fetch_valid !== 1'b1 || cmd_address_current !== 32'h0) begin bad++; $display("FAIL run0 got fv=%b pc=%h exp 1/0", fetch_valid, cmd_address_current); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++; if (cmd_address_current !== 32'(4 * i)) begin bad++; $display("FAIL seq%0d got=%h exp=%h", i, cmd_address_current, 32'(4 * i)); end
        end
    endtask

    task automatic test_backpressure();
        do_redirect(32'h10);
        fetch_ready = 1'b0;
        #1;
        total++; if (cmd_address_next !== 32'h10) begin bad++; $display("FAIL bp_next got=%h exp=10", cmd_address_next); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (cmd_address_current !== 32'h10 || fetch_valid !== 1'b1) begin bad++; $display("FAIL bp_hold%0d got pc=%h fv=%b exp 10/1", i, cmd_address_current, fetch_valid); end
        end
        fetch_ready = 1'b1;
        tick();
        total++; if (cmd_address_current !== 32'h14) begin bad++; $display("FAIL bp_resume got=%h exp=14", cmd_address_current); end
    endtask

    task automatic test_redirect();
        stall = 1'b1;
        redirect_valid = 1'b1; redirect_target = 32'h200;
        #1;
        total++; if (cmd_address_next !== 32'h200) begin bad++; $display("FAIL redir_next got=%h exp=200", cmd_address_next); end
        tick();
        stall = 1'b0; redirect_valid = 1'b0;
        total++; if (cmd_address_current !== 32'h200) begin bad++; $display("FAIL redir_stall got=%h exp=200", cmd_address_current); end
        redirect_is_jalr = 1'b1;
        do_redirect(32'h301);
        redirect_is_jalr = 1'b0;
        total++; if (cmd_address_current !== 32'h300 || misaligned !== 1'b0) begin bad++; $display("FAIL jalr got pc=%h mis=%b exp 300/0", cmd_address_current, misaligned); end
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_target = 32'h202;
        #1;
`ifdef PC_GEN_COMPRESSED_EN
        total++; if (cmd_address_next !== 32'h202) begin bad++; $display("FAIL mis_next got=%h exp=202", cmd_address_next); end
        tick();
        redirect_valid = 1'b0;
        total++; if (cmd_address_current !== 32'h202 || misaligned !== 1'b0 || epc !== 32'h0) begin bad++; $display("FAIL mis_c got pc=%h mis=%b epc=%h exp 202/0/0", cmd_address_current, misaligned, epc); end
        tick();
        total++; if (cmd_address_current !== 32'h206) begin bad++; $display("FAIL inc4 got=%h exp=206", cmd_address_current); end
        is_compressed = 1'b1;
        tick();
        is_compressed = 1'b0;
        total++; if (cmd_address_current !== 32'h208) begin bad++; $display("FAIL inc2 got=%h exp=208", cmd_address_current); end
`else
        total++; if (cmd_address_next !== 32'h100) begin bad++; $display("FAIL mis_next got=%h exp=100", cmd_address_next); end
        tick();
        redirect_valid = 1'b0;
        total++; if (cmd_address_current !== 32'h100 || epc !== 32'h202 || misaligned !== 1'b1) begin bad++; $display("FAIL mis got pc=%h epc=%h mis=%b exp 100/202/1", cmd_address_current, epc, misaligned); end
        tick();
        total++; if (misaligned !== 1'b0 || cmd_address_current !== 32'h104 || epc !== 32'h202) begin bad++; $display("FAIL mis_clr got mis=%b pc=%h epc=%h exp 0/104/202", misaligned, cmd_address_current, epc); end
`endif
    endtask

    task automatic test_trap();
        do_redirect(32'h40);
        trap_valid = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h500; halt_req = 1'b1;
        tick();
        trap_valid = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0;
        #1;
        total++; if (cmd_address_current !== 32'h100 || epc !== 32'h40) begin bad++; $display("FAIL trap got pc=%h epc=%h exp 100/40", cmd_address_current, epc); end
        total++; if (fetch_valid !== 1'b1 || misaligned !== 1'b0) begin bad++; $display("FAIL trap_run got fv=%b mis=%b exp 1/0", fetch_valid, misaligned); end
        do_redirect(32'hFFFF_FFFC);
        tick();
        total++; if (cmd_address_current !== 32'h0 || epc !== 32'h40) begin bad++; $display("FAIL wrap got pc=%h epc=%h exp 0/40", cmd_address_current, epc); end
    endtask

    task automatic test_halt();
        do_redirect(32'h20);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        total++; if (cmd_address_current !== 32'h24 || fetch_valid !== 1'b0) begin bad++; $display("FAIL halt_enter got pc=%h fv=%b exp 24/0", cmd_address_current, fetch_valid); end
        redirect_valid = 1'b1; redirect_target = 32'h800;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (cmd_address_next !== 32'h24) begin bad++; $display("FAIL halt_next%0d got=%h exp=24", i, cmd_address_next); end
            tick();
            total++; if (cmd_address_current !== 32'h24 || fetch_valid !== 1'b0) begin bad++; $display("FAIL halt_hold%0d got pc=%h fv=%b exp 24/0", i, cmd_address_current, fetch_valid); end
        end
        redirect_valid = 1'b0;
        resume = 1'b1;
        tick();
        resume = 1'b0;
        total++; if (cmd_address_current !== 32'h24 || fetch_valid !== 1'b1) begin bad++; $display("FAIL resume got pc=%h fv=%b exp 24/1", cmd_address_current, fetch_valid); end
        tick();
        total++; if (cmd_address_current !== 32'h28) begin bad++; $display("FAIL post_resume got=%h exp=28", cmd_address_current); end
        halt_req = 1'b1;
        tick();
        resume = 1'b1;
        tick();
        halt_req = 1'b0; resume = 1'b0;
        total++; if (fetch_valid !== 1'b0 || cmd_address_current !== 32'h2C) begin bad++; $display("FAIL halt_resume_both got fv=%b pc=%h exp 0/2c", fetch_valid, cmd_address_current); end
        trap_valid = 1'b1;
        tick();
        trap_valid = 1'b0;
        total++; if (cmd_address_current !== 32'h100 || epc !== 32'h2C || fetch_valid !== 1'b1) begin bad++; $display("FAIL halt_trap got pc=%h epc=%h fv=%b exp 100/2c/1", cmd_address_current, epc, fetch_valid); end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        total++; if (cmd_address_current !== 32'h104 || fetch_valid !== 1'b0) begin bad++; $display("FAIL halt2 got pc=%h fv=%b exp 104/0", cmd_address_current, fetch_valid); end
        #2;
        a_reset_n = 1'b0;
        #1;
        total++; if (cmd_address_current !== 32'h0 || epc !== 32'h0 || fetch_valid !== 1'b0) begin bad++; $display("FAIL async_rst got pc=%h epc=%h fv=%b exp 0/0/0", cmd_address_current, epc, fetch_valid); end
        @(negedge clk);
        a_reset_n = 1'b1;
        tick();
        total++; if (cmd_address_current !== 32'h0 || fetch_valid !== 1'b1) begin bad++; $display("FAIL reboot got pc=%h fv=%b exp 0/1", cmd_address_current, fetch_valid); end
        tick();
        total++; if (cmd_address_current !== 32'h4) begin bad++; $display("FAIL reboot_inc got=%h exp=4", cmd_address_current); end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_redirect();
        test_misalign();
        test_trap();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator; successor to the single-register pc block.
- Holds the fetch address and computes the next PC from these sources, in priority order: trap, redirect, stall/back-pressure, sequential increment.
- Drives a valid/ready fetch handshake toward instruction memory.
- Sits between the branch/execute stage and the instruction memory port.

Parameters:
- XLEN, 32, address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap or misaligned redirect.
- INC, 4, sequential increment in bytes.

Ports:
- clk  in  1  rising-edge clock.
- a_reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC (pipeline hazard).
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  XLEN  redirect destination.
- redirect_is_jalr  in  1  clear bit 0 of redirect_target before use.
- trap_valid  in  1  synchronous exception/interrupt request.
- halt_req  in  1  enter HALT.
- resume  in  1  leave HALT.
- fetch_ready  in  1  instruction memory accepts the address.
- fetch_valid  out  1  cmd_address_current is a valid fetch request.
- cmd_address_current  out  XLEN  registered current PC.
- cmd_address_next  out  XLEN  combinational value PC takes at the next edge.
- epc  out  XLEN  PC saved on trap or misalignment.
- misaligned  out  1  one-cycle pulse on a misaligned redirect.

Behaviour:
- Reset (asynchronous, a_reset_n=0):
  - pc=RESET_VECTOR, state=BOOT, fetch_valid=0, epc=0, misaligned=0.
  - cmd_address_next=RESET_VECTOR.
- States:
  - BOOT: lasts exactly one cycle after reset release; pc holds; fetch_valid=0; always goes to RUN.
  - RUN: fetch_valid=1.
  - HALT: fetch_valid=0; pc holds.
- Next-PC evaluation in RUN, one edge of latency, first match wins:
  1. trap_valid: pc<=TRAP_VECTOR; epc<=pc.
  2. redirect_valid:
     - Effective target t = redirect_target, with bit 0 forced to 0 when redirect_is_jalr=1.
     - If t[1:0]!=0: pc<=TRAP_VECTOR; epc<=t; misaligned<=1 for one cycle.
     - Otherwise: pc<=t.
  3. stall=1 or fetch_ready=0: pc holds. fetch_valid stays 1 and the address stays stable until accepted.
  4. Otherwise: pc<=pc+INC, modulo 2^XLEN (0xFFFF_FFFC+4 = 0).
- Redirect and trap override back-pressure: the pending request is dropped and the new address is presented next cycle.
- HALT entry and exit:
  - halt_req=1 in RUN: the PC update for that cycle still happens, then state=HALT.
  - trap_valid has priority over halt_req in the same cycle: trap taken, state stays RUN.
  - In HALT: redirect_valid is ignored. trap_valid loads TRAP_VECTOR, saves epc=pc and returns to RUN.
  - resume=1 (without trap) returns to RUN; the held pc is fetched next cycle.
  - halt_req and resume both high: resume ignored; state remains/becomes HALT.
- cmd_address_next always equals the value pc takes at the next edge, including in BOOT and HALT (equals pc when holding).
- misaligned is registered and cleared the following cycle.
- epc updates only on trap or misalignment.
- Asserting reset mid-operation clears all state immediately, regardless of the clock.

Optional Feature:
- Macro PC_GEN_COMPRESSED_EN.
- Defined:
  - Adds input is_compressed (1 bit); the sequential increment becomes 2 when it is 1, otherwise INC.
  - Misalignment check uses t[0] only, so 2-byte-aligned targets are legal.
  - JALR bit-0 clearing still applies.
- Undefined: no is_compressed port; increment is always INC; t[1:0]!=0 is misaligned.

Decomposition:
- Package pc_pkg:
  - typedef enum logic [1:0] pc_state_t {BOOT, RUN, HALT}.
  - typedef enum next_sel_t {SEL_HOLD, SEL_INC, SEL_REDIRECT, SEL_TRAP}.
  - Localparam defaults for RESET_VECTOR and TRAP_VECTOR.
- One natural sub-module, pc_next_mux: purely combinational priority/target/misalign logic producing next_sel, next_pc and misalign_hit. pc_gen holds the registers and the FSM.

Test Plan:
- Reset then release, fetch_ready=1 -> BOOT cycle with pc=0 and fetch_valid=0; then fetch addresses 0,4,8,12 on consecutive cycles.
- fetch_ready=0 for 3 cycles at pc=0x10 -> cmd_address_current stays 0x10 with fetch_valid=1; resumes at 0x14 after ready returns.
- redirect_valid with target 0x200 while stall=1 -> pc=0x200 next cycle. JALR target 0x301 -> pc=0x300.
- redirect target 0x202, macro undefined -> pc=0x100, epc=0x202, misaligned high exactly one cycle. Same stimulus with PC_GEN_COMPRESSED_EN -> pc=0x202, no pulse.
- trap_valid and redirect_valid together at pc=0x40 -> pc=0x100, epc=0x40, redirect ignored. pc=0xFFFF_FFFC incrementing -> wraps to 0x0.
- halt_req at pc=0x20 -> next pc=0x24, then HALT with fetch_valid=0 for 5 cycles while redirects are ignored. resume -> fetch 0x24. Reset asserted mid-HALT -> immediate pc=0, state BOOT.
